reg_bank_shadow: RTL and testbench
==================================

Name: reg_bank_shadow

Overview:
Parametrised register bank: NUM_REGS registers, each with its own reset/init value, behind a valid/ready request and response interface. Software writes land in a shadow copy. A commit pulse transfers shadow to the active copy that drives the datapath, so multi-register updates appear atomically. Per-register read-only mode exposes hardware status inputs. Sits between the control-bus bridge and datapath configuration ports.

Parameters:
NUM_REGS, 4, number of 32-bit-addressable registers (1..64)
DATA_W, 32, register width, multiple of 8
ADDR_W, 6, request word-address width; must satisfy 2**ADDR_W >= NUM_REGS
INIT_VALUES, {NUM_REGS*DATA_W{1'b0}}, packed init values; register i = bits [i*DATA_W +: DATA_W]
RO_MASK, {NUM_REGS{1'b0}}, bit i = 1 makes register i read-only (reads hw_status slice)

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  bank can accept request
req_write  in  1  1 = write, 0 = read
req_addr  in  ADDR_W  word address
req_wdata  in  DATA_W  write data
req_wstrb  in  DATA_W/8  byte-lane write enables
rsp_valid  out  1  response present
rsp_ready  in  1  response consumer ready
rsp_rdata  out  DATA_W  read data; 0 for writes and errors
rsp_err  out  1  bad address or write to read-only register
commit  in  1  pulse: copy all RW shadow registers to active
soft_clr  in  1  pulse: reload INIT_VALUES into shadow and active
commit_done  out  1  one-cycle pulse, cycle after commit accepted
hw_status  in  NUM_REGS*DATA_W  status inputs for RO registers
active_regs  out  NUM_REGS*DATA_W  active register values to datapath

Behaviour:
- Reset: reset_n is synchronous and active-low; clock is clk. During reset, shadow and active = INIT_VALUES, rsp_valid=0, rsp_rdata=0, rsp_err=0, commit_done=0, FSM=IDLE. A pending response is discarded.
- FSM has two states:
  - IDLE: req_ready=1. On req_valid, perform the access this cycle and go to RESP.
  - RESP: req_ready=0, rsp_valid=1. When rsp_ready=1, return to IDLE.
  - Minimum period is 2 cycles per transaction. Response data and err are registered and stable while rsp_valid=1 and rsp_ready=0.
- Address decode:
  - req_addr >= NUM_REGS: rsp_err=1, rdata=0, no state change.
- Read:
  - RW register: rdata = shadow value, err=0.
  - RO register: rdata = hw_status slice sampled in the accept cycle, err=0.
- Write to an RW register: shadow byte lane b is updated iff req_wstrb[b]=1. err=0. Active is unchanged.
- Write to an RO register: err=1, no state change.
- Write with wstrb=0: no state change, err=0.
- commit=1: active[i] <= shadow[i] for all RW registers. commit_done=1 the next cycle.
  - commit in RESP or IDLE is always honoured.
  - RO register active slices mirror hw_status, registered one cycle.
- Same-cycle write and commit: active takes the shadow value from before the write; the write lands in shadow only.
- soft_clr has highest priority:
  - Shadow and active (RW) reload INIT_VALUES. A same-cycle write or commit is ignored for register state.
  - The transaction still completes with err=0.
  - commit_done is not generated.
  - FSM state is unaffected.
- active_regs is driven directly from the active flops, with no combinational path from request inputs.

Test Plan:
- Reset with NUM_REGS=4, INIT = {0x01020304, 0x1a1b1c1d, 0x0a0b0c0d, 0x2a2b2c2d} (reg3..reg0) -> active_regs slices equal INIT; read of addr 1 returns 0x0a0b0c0d, err=0.
- Write addr 2, wdata 0xFFFFFFFF, wstrb 4'b0101 -> shadow reg2 = 0x1aFF1cFF; active reg2 still 0x1a1b1c1d; after commit pulse, active reg2 = 0x1aFF1cFF and commit_done pulses exactly one cycle later.
- Write addr 5 (>= NUM_REGS), and write to reg3 with RO_MASK=4'b1000 -> both give rsp_err=1, no register change. Read reg3 with hw_status slice 0xDEADBEEF -> rdata 0xDEADBEEF.
- Hold rsp_ready=0 for 5 cycles after a read -> rsp_valid and rsp_rdata stable, req_ready=0 throughout; a req_valid presented meanwhile is accepted only after the response handshake.
- Write reg0 = 0x12345678 and commit in the same cycle -> active reg0 = 0x2a2b2c2d, shadow reg0 = 0x12345678. A second commit moves 0x12345678 to active.
- soft_clr during an in-flight write; separately, reset_n low while rsp_valid=1 -> soft_clr: all registers return to INIT, response err=0. Reset: rsp_valid drops to 0 the next cycle and registers return to INIT.

Source files
------------

// File: rtl/reg_bank_shadow.sv
// Register bank with a shadow/active copy per register, valid/ready access port,
// atomic commit of shadow to active, and per-register read-only status mirrors.
module reg_bank_shadow #(
   parameter int unsigned                  NUM_REGS    = 4,
   parameter int unsigned                  DATA_W      = 32,
   parameter int unsigned                  ADDR_W      = 6,
   parameter logic [NUM_REGS*DATA_W-1:0]   INIT_VALUES = '0,
   parameter logic [NUM_REGS-1:0]          RO_MASK     = '0
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         req_valid,
   output logic                         req_ready,
   input  logic                         req_write,
   input  logic [ADDR_W-1:0]            req_addr,
   input  logic [DATA_W-1:0]            req_wdata,
   input  logic [DATA_W/8-1:0]          req_wstrb,
   output logic                         rsp_valid,
   input  logic                         rsp_ready,
   output logic [DATA_W-1:0]            rsp_rdata,
   output logic                         rsp_err,
   input  logic                         commit,
   input  logic                         soft_clr,
   output logic                         commit_done,
   input  logic [NUM_REGS*DATA_W-1:0]   hw_status,
   output logic [NUM_REGS*DATA_W-1:0]   active_regs
);

   localparam int unsigned NB = DATA_W / 8;

   typedef enum logic {IDLE, RESP} state_t;

   state_t                       state;
   logic [NUM_REGS*DATA_W-1:0]   shadow;
   logic [NUM_REGS*DATA_W-1:0]   active;
   logic                         accept;
   logic [DATA_W-1:0]            rd_val;
   logic                         rd_err;
   logic [NUM_REGS-1:0]          wr_sel;

   assign active_regs = active;

   // Unmatched addresses fall through with rd_err still set.
   always_comb begin
      accept = req_valid && req_ready;
      rd_val = '0;
      rd_err = 1'b1;
      wr_sel = '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
         if (req_addr == ADDR_W'(i)) begin
            rd_err = req_write && RO_MASK[i];
            if (!req_write)
               rd_val = RO_MASK[i] ? hw_status[i*DATA_W +: DATA_W] : shadow[i*DATA_W +: DATA_W];
            wr_sel[i] = accept && req_write && !RO_MASK[i];
         end
      end
      if (soft_clr)
         rd_err = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state       <= IDLE;
         req_ready   <= 1'b1;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
         commit_done <= 1'b0;
         shadow      <= INIT_VALUES;
         active      <= INIT_VALUES;
      end else begin
         commit_done <= commit && !soft_clr;

         // Commit reads shadow before this cycle's write lands, so a same-cycle
         // write is only visible in active after a later commit.
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (RO_MASK[i]) begin
               active[i*DATA_W +: DATA_W] <= hw_status[i*DATA_W +: DATA_W];
            end else if (soft_clr) begin
               shadow[i*DATA_W +: DATA_W] <= INIT_VALUES[i*DATA_W +: DATA_W];
               active[i*DATA_W +: DATA_W] <= INIT_VALUES[i*DATA_W +: DATA_W];
            end else begin
               if (commit)
                  active[i*DATA_W +: DATA_W] <= shadow[i*DATA_W +: DATA_W];
               if (wr_sel[i]) begin
                  for (int unsigned b = 0; b < NB; b++) begin
                     if (req_wstrb[b])
                        shadow[i*DATA_W + b*8 +: 8] <= req_wdata[b*8 +: 8];
                  end
               end
            end
         end

         case (state)
            IDLE: begin
               if (req_valid) begin
                  state     <= RESP;
                  req_ready <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_rdata <= rd_err ? '0 : rd_val;
                  rsp_err   <= rd_err;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  state     <= IDLE;
                  req_ready <= 1'b1;
                  rsp_valid <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               req_ready <= 1'b1;
               rsp_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_reg_bank_shadow.sv
// Directed bench for reg_bank_shadow: responses checked by a queue-based monitor,
// register state and commit_done checked inline.
module tb_reg_bank_shadow;

   localparam logic [127:0] INIT = 128'h01020304_1a1b1c1d_0a0b0c0d_2a2b2c2d;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          req_valid, req_ready, req_write;
   logic [5:0]    req_addr;
   logic [31:0]   req_wdata;
   logic [3:0]    req_wstrb;
   logic          rsp_valid, rsp_ready, rsp_err;
   logic [31:0]   rsp_rdata;
   logic          commit, soft_clr, commit_done;
   logic [127:0]  hw_status, active_regs;

   int            total = 0;
   int            bad   = 0;
   logic [32:0]   exp_q[$];

   reg_bank_shadow #(
      .NUM_REGS(4), .DATA_W(32), .ADDR_W(6),
      .INIT_VALUES(INIT), .RO_MASK(4'b1000)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .commit(commit), .soft_clr(soft_clr),
      .commit_done(commit_done), .hw_status(hw_status), .active_regs(active_regs)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   function automatic logic [31:0] act(input int k);
      return active_regs[k*32 +: 32];
   endfunction

   // Response monitor
   initial begin
      forever begin
         @(negedge clk);
         if (reset_n && rsp_valid && rsp_ready) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL rsp_unexpected: got err=%0b rdata=%0h expected none", rsp_err, rsp_rdata);
            end else begin
               logic [32:0] e;
               e = exp_q.pop_front();
               if ({rsp_err, rsp_rdata} !== e) begin
                  bad++;
                  $display("FAIL rsp: got err=%0b rdata=%0h expected err=%0b rdata=%0h",
                           rsp_err, rsp_rdata, e[32], e[31:0]);
               end
            end
         end
      end
   end

   task automatic do_req(input logic wr, input logic [5:0] a, input logic [31:0] wd,
                         input logic [3:0] st, input logic [32:0] e, input bit push,
                         input logic clr, input logic cmt);
      int n;
      @(posedge clk); #1;
      n = 0;
      while (!req_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!req_ready) begin
         check("req_ready_timeout", 128'(req_ready), 128'(1'b1));
         return;
      end
      if (push) exp_q.push_back(e);
      req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd; req_wstrb = st;
      soft_clr = clr; commit = cmt;
      @(posedge clk); #1;
      req_valid = 1'b0; req_write = 1'b0; soft_clr = 1'b0; commit = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || rsp_valid) && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (exp_q.size() != 0 || rsp_valid)
         check("idle_timeout", 128'(exp_q.size()), 128'(0));
   endtask

   task automatic pulse_commit(input string name, input logic [31:0] exp_r0, input int k);
      @(posedge clk); #1;
      commit = 1'b1;
      @(posedge clk); #1;
      commit = 1'b0;
      check({name, "_done"}, 128'(commit_done), 128'(1'b1));
      check({name, "_active"}, 128'(act(k)), 128'(exp_r0));
      @(posedge clk); #1;
      check({name, "_done_clear"}, 128'(commit_done), 128'(1'b0));
   endtask

   initial begin
      reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
      req_wdata = '0; req_wstrb = '0; rsp_ready = 1'b1; commit = 1'b0; soft_clr = 1'b0;
      hw_status = {32'hDEADBEEF, 96'h0};

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_active", active_regs, INIT);
      check("reset_rsp_valid", 128'(rsp_valid), 128'(1'b0));
      check("reset_commit_done", 128'(commit_done), 128'(1'b0));
      @(posedge clk); #1;
      reset_n = 1'b1;

      do_req(1'b0, 6'd1, '0, '0, {1'b0, 32'h0a0b0c0d}, 1, 1'b0, 1'b0);
      wait_idle();

      // Partial-strobe write, then commit
      do_req(1'b1, 6'd2, 32'hFFFFFFFF, 4'b0101, 33'h0, 1, 1'b0, 1'b0);
      do_req(1'b0, 6'd2, '0, '0, {1'b0, 32'h1aFF1cFF}, 1, 1'b0, 1'b0);
      wait_idle();
      check("precommit_active2", 128'(act(2)), 128'h1a1b1c1d);
      pulse_commit("commit1", 32'h1aFF1cFF, 2);

      // Errors and read-only status
      do_req(1'b1, 6'd5, 32'h11111111, 4'hF, {1'b1, 32'h0}, 1, 1'b0, 1'b0);
      do_req(1'b1, 6'd3, 32'h11111111, 4'hF, {1'b1, 32'h0}, 1, 1'b0, 1'b0);
      do_req(1'b0, 6'd3, '0, '0, {1'b0, 32'hDEADBEEF}, 1, 1'b0, 1'b0);
      do_req(1'b0, 6'd5, '0, '0, {1'b1, 32'h0}, 1, 1'b0, 1'b0);
      wait_idle();
      check("ro_active3", 128'(act(3)), 128'hDEADBEEF);
      check("err_no_change", active_regs[95:0], 96'h1aFF1cFF_0a0b0c0d_2a2b2c2d);

      // Back-pressure: response held, second request waits
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      do_req(1'b0, 6'd0, '0, '0, {1'b0, 32'h2a2b2c2d}, 1, 1'b0, 1'b0);
      exp_q.push_back({1'b0, 32'h0a0b0c0d});
      req_valid = 1'b1; req_write = 1'b0; req_addr = 6'd1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("stall_valid", 128'(rsp_valid), 128'(1'b1));
         check("stall_rdata", 128'(rsp_rdata), 128'h2a2b2c2d);
         check("stall_ready", 128'(req_ready), 128'(1'b0));
      end
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      begin
         int n;
         n = 0;
         while (!req_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
         end
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      wait_idle();

      // Same-cycle write and commit
      do_req(1'b1, 6'd0, 32'h12345678, 4'hF, 33'h0, 1, 1'b0, 1'b1);
      check("wc_done", 128'(commit_done), 128'(1'b1));
      check("wc_active0", 128'(act(0)), 128'h2a2b2c2d);
      do_req(1'b0, 6'd0, '0, '0, {1'b0, 32'h12345678}, 1, 1'b0, 1'b0);
      wait_idle();
      pulse_commit("commit2", 32'h12345678, 0);

      // soft_clr with in-flight write and commit
      do_req(1'b1, 6'd1, 32'h55555555, 4'hF, 33'h0, 1, 1'b1, 1'b1);
      check("clr_no_done", 128'(commit_done), 128'(1'b0));
      wait_idle();
      check("clr_active", active_regs[95:0], INIT[95:0]);
      do_req(1'b0, 6'd0, '0, '0, {1'b0, 32'h2a2b2c2d}, 1, 1'b0, 1'b0);
      do_req(1'b0, 6'd1, '0, '0, {1'b0, 32'h0a0b0c0d}, 1, 1'b0, 1'b0);
      do_req(1'b0, 6'd2, '0, '0, {1'b0, 32'h1a1b1c1d}, 1, 1'b0, 1'b0);
      wait_idle();

      // Reset while a response is pending
      do_req(1'b1, 6'd0, 32'h11111111, 4'hF, 33'h0, 1, 1'b0, 1'b0);
      wait_idle();
      pulse_commit("commit3", 32'h11111111, 0);
      rsp_ready = 1'b0;
      do_req(1'b0, 6'd2, '0, '0, 33'h0, 0, 1'b0, 1'b0);
      check("pre_rst_valid", 128'(rsp_valid), 128'(1'b1));
      reset_n = 1'b0;
      @(posedge clk); #1;
      check("rst_valid", 128'(rsp_valid), 128'(1'b0));
      check("rst_rdata", 128'(rsp_rdata), 128'h0);
      check("rst_active", active_regs, INIT);
      reset_n = 1'b1;
      rsp_ready = 1'b1;
      do_req(1'b0, 6'd0, '0, '0, {1'b0, 32'h2a2b2c2d}, 1, 1'b0, 1'b0);
      wait_idle();
      check("queue_drained", 128'(exp_q.size()), 128'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
